mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single shared memory request channel.
// A grant is decided combinationally. The arbiter locks onto the granted port until
// the memory completes the request or the requester withdraws it. When both ports
// request in the same idle cycle, round-robin priority picks the winner.
module mem_arbiter #(
  parameter int unsigned RISCV_ADDR_WIDTH = 32,
  parameter int unsigned RISCV_WORD_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  // Instruction port (read only)
  input  logic                        i_valid_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] i_addr_i,
  output logic                        i_ready_o,
  output logic [RISCV_WORD_WIDTH-1:0] i_rdata_o,
  // Data port
  input  logic                        d_valid_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] d_addr_i,
  input  logic [RISCV_WORD_WIDTH-1:0] d_wdata_i,
  input  logic [3:0]                  d_we_i,
  output logic                        d_ready_o,
  output logic [RISCV_WORD_WIDTH-1:0] d_rdata_o,
  // Shared memory channel
  output logic                        mem_valid_o,
  input  logic                        mem_ready_i,
  output logic [RISCV_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [RISCV_WORD_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]                  mem_we_o,
  input  logic [RISCV_WORD_WIDTH-1:0] mem_rdata_i,
  output logic [1:0]                  owner_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StLockI = 2'b01,
    StLockD = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    GntNone = 2'b00,
    GntI    = 2'b01,
    GntD    = 2'b10
  } grant_e;

  state_e state_q, state_d;
  // 1: the data port completed most recently, so the instruction port wins a tie.
  logic   last_d_q, last_d_d;
  // Holds grants off until the first clock edge after reset is released.
  logic   run_q, run_d;
  grant_e grant;
  logic   done;

  // Arbitration enable: cleared by reset, set on the first clock edge after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
    end else begin
      run_q <= run_d;
    end
  end

  // FSM state and round-robin pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      last_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  // Combinational grant; reset gates it directly so mem_valid_o drops asynchronously
  always_comb begin
    grant = GntNone;
    if (!rst && run_q) begin
      unique case (state_q)
        StIdle: begin
          if (i_valid_i && d_valid_i) begin
            grant = last_d_q ? GntI : GntD;
          end else if (i_valid_i) begin
            grant = GntI;
          end else if (d_valid_i) begin
            grant = GntD;
          end
        end
        StLockI: if (i_valid_i) grant = GntI;
        StLockD: if (d_valid_i) grant = GntD;
        default: grant = GntNone;
      endcase
    end
  end

  // A ready counts only when a request is actually presented
  always_comb begin
    done = mem_ready_i && (grant != GntNone);
  end

  // Next-state and round-robin pointer update
  always_comb begin
    run_d    = 1'b1;
    state_d  = state_q;
    last_d_d = last_d_q;
    if (done) begin
      last_d_d = (grant == GntD);
    end
    unique case (state_q)
      StIdle: begin
        if (grant == GntI && !mem_ready_i) begin
          state_d = StLockI;
        end else if (grant == GntD && !mem_ready_i) begin
          state_d = StLockD;
        end
      end
      // Leave the lock on completion or when the owner withdraws its request
      StLockI: if (grant != GntI || done) state_d = StIdle;
      StLockD: if (grant != GntD || done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request payload mux and per-port ready steering
  always_comb begin
    mem_valid_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 4'b0000;
    i_ready_o   = 1'b0;
    d_ready_o   = 1'b0;
    unique case (grant)
      GntI: begin
        mem_valid_o = i_valid_i;
        mem_addr_o  = i_addr_i;
        i_ready_o   = mem_ready_i;
      end
      GntD: begin
        mem_valid_o = d_valid_i;
        mem_addr_o  = d_addr_i;
        mem_wdata_o = d_wdata_i;
        mem_we_o    = d_we_i;
        d_ready_o   = mem_ready_i;
      end
      default: begin
        mem_valid_o = 1'b0;
      end
    endcase
  end

  // Read data is shared by both ports; only the ready qualifies it
  always_comb begin
    i_rdata_o = mem_rdata_i;
    d_rdata_o = mem_rdata_i;
    owner_o   = grant;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and checks them whenever a port ready appears.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid_i;
  logic [AW-1:0] i_addr_i;
  logic          i_ready_o;
  logic [DW-1:0] i_rdata_o;
  logic          d_valid_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [3:0]    d_we_i;
  logic          d_ready_o;
  logic [DW-1:0] d_rdata_o;
  logic          mem_valid_o;
  logic          mem_ready_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [3:0]    mem_we_o;
  logic [DW-1:0] mem_rdata_i;
  logic [1:0]    owner_o;

  mem_arbiter #(
    .RISCV_ADDR_WIDTH(AW),
    .RISCV_WORD_WIDTH(DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid_i  (i_valid_i),
    .i_addr_i   (i_addr_i),
    .i_ready_o  (i_ready_o),
    .i_rdata_o  (i_rdata_o),
    .d_valid_i  (d_valid_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_we_i     (d_we_i),
    .d_ready_o  (d_ready_o),
    .d_rdata_o  (d_rdata_o),
    .mem_valid_o(mem_valid_o),
    .mem_ready_i(mem_ready_i),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_we_o   (mem_we_o),
    .mem_rdata_i(mem_rdata_i),
    .owner_o    (owner_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Memory model: read data is a fixed function of the presented address
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  always_comb mem_rdata_i = rd_model(mem_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_i(input logic [31:0] a);
    exp_t e;
    e.port = 2'b01; e.addr = a; e.wdata = 32'h0; e.we = 4'h0;
    sb.push_back(e);
  endtask

  task automatic push_d(input logic [31:0] a, input logic [31:0] w, input logic [3:0] we);
    exp_t e;
    e.port = 2'b10; e.addr = a; e.wdata = w; e.we = we;
    sb.push_back(e);
  endtask

  // Apply one cycle of inputs shortly after the rising edge
  task automatic step(input logic iv, input logic dv, input logic rdy);
    @(posedge clk);
    #1;
    i_valid_i   = iv;
    d_valid_i   = dv;
    mem_ready_i = rdy;
  endtask

  // Monitor: every port ready must match the oldest expected completion
  always @(negedge clk) begin
    if (i_ready_o || d_ready_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", {30'd0, i_ready_o, d_ready_o}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("owner", {30'd0, owner_o}, {30'd0, mon_e.port});
        chk("i_ready", {31'd0, i_ready_o}, {31'd0, mon_e.port == 2'b01});
        chk("d_ready", {31'd0, d_ready_o}, {31'd0, mon_e.port == 2'b10});
        chk("mem_addr", mem_addr_o, mon_e.addr);
        chk("mem_wdata", mem_wdata_o, mon_e.wdata);
        chk("mem_we", {28'd0, mem_we_o}, {28'd0, mon_e.we});
        chk("rdata", (mon_e.port == 2'b01) ? i_rdata_o : d_rdata_o, rd_model(mon_e.addr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    i_valid_i   = 1'b1;
    i_addr_i    = 32'h100;
    d_valid_i   = 1'b1;
    d_addr_i    = 32'h200;
    d_wdata_i   = 32'h1111_2222;
    d_we_i      = 4'h3;
    mem_ready_i = 1'b1;

    // Reset held with both requests and ready asserted: everything stays quiet
    repeat (2) @(negedge clk);
    chk("rst_mem_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("rst_owner", {30'd0, owner_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_we", {28'd0, mem_we_o}, 32'd0);

    // Release cycle: no grant yet
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("release_no_grant", {31'd0, mem_valid_o}, 32'd0);

    // Instruction-only burst with zero-wait memory: four completions
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b1);
      push_i(32'h100);
    end
    step(1'b0, 1'b0, 1'b0);

    // Fresh reset, then both valid with zero-wait memory: I, D, I, D
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b1);
      if (k % 2 == 0) push_i(32'h100);
      else push_d(32'h200, 32'h1111_2222, 4'h3);
    end
    step(1'b0, 1'b0, 1'b0);

    // One instruction fetch so the data port wins the next tie
    step(1'b1, 1'b0, 1'b1);
    push_i(32'h100);
    // Data write locked for three wait cycles with instruction pending throughout
    d_addr_i  = 32'h20;
    d_wdata_i = 32'hDEAD_BEEF;
    d_we_i    = 4'hF;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk("lockd_owner", {30'd0, owner_o}, 32'd2);
      chk("lockd_addr", mem_addr_o, 32'h20);
      chk("lockd_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    end
    step(1'b1, 1'b1, 1'b1);
    push_d(32'h20, 32'hDEAD_BEEF, 4'hF);
    step(1'b1, 1'b0, 1'b1);
    push_i(32'h100);
    step(1'b0, 1'b0, 1'b0);

    // Lock abort: instruction withdraws while locked, pending data then granted
    d_addr_i  = 32'h300;
    d_wdata_i = 32'h0;
    d_we_i    = 4'h0;
    step(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("locki_owner", {30'd0, owner_o}, 32'd1);
    step(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("abort_mem_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("abort_owner", {30'd0, owner_o}, 32'd0);
    step(1'b0, 1'b1, 1'b1);
    push_d(32'h300, 32'h0, 4'h0);

    // Stray ready with no request: no completion, pointer untouched (I wins next)
    step(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("stray_mem_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("stray_readies", {30'd0, i_ready_o, d_ready_o}, 32'd0);
    step(1'b1, 1'b1, 1'b1);
    push_i(32'h100);
    step(1'b0, 1'b0, 1'b0);

    // Reset pulse during LOCK_D: request drops at once, instruction wins afterwards
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #1;
    chk("pre_rst_owner", {30'd0, owner_o}, 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("async_rst_owner", {30'd0, owner_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_release", {31'd0, mem_valid_o}, 32'd0);
    step(1'b1, 1'b1, 1'b1);
    push_i(32'h100);
    step(1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
